// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
//   stage_state_t   : occupancy state of a stage (EMPTY, FULL, SKIDFULL)
//   PIPE_NOP        : canonical no-op instruction word, used as the bubble
//                     value by stages that carry instructions
//   state_occupancy : number of held entries for a given state
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    SKIDFULL = 2'd2
  } stage_state_t;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

  function automatic logic [1:0] state_occupancy(input stage_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      EMPTY:    occ = 2'd0;
      FULL:     occ = 2'd1;
      SKIDFULL: occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_dreg.sv
// Parametrised payload register with load enable.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, loads RST_VAL
//   en      : load d into q on the next rising edge
//   d / q   : WIDTH-bit data in / registered data out
module pipe_stage_reg_dreg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer.
//   clk, rst            : clock and asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data is the payload
//   out_valid/out_ready : downstream handshake, out_data is the head payload
//                         (BUBBLE when the stage is empty)
//   flush               : discards held and incoming beats
//   clr_cnt / stall_cnt : clear / saturating count of back-pressured cycles
//   occupancy           : number of held entries (0..2)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       occupancy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_state_t     state;
  stage_state_t     next_state;
  logic             in_ready_q;
  logic [CNT_W-1:0] stall_q;
  logic             accept;
  logic             pop;
  logic             head_load;
  logic             head_from_skid;
  logic             skid_load;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // With a skid entry, in_ready comes straight from a flop so that no
  // combinational path runs from out_ready back to upstream.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

  assign out_data  = out_valid ? head_q : BUBBLE;
  assign stall_cnt = stall_q;
  assign occupancy = state_occupancy(state);

  // Next-state and storage-enable decode. An accept while FULL without a pop
  // can only happen with a skid entry; without one, in_ready forces a pop.
  always_comb begin
    next_state     = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            next_state = FULL;
            head_load  = 1'b1;
          end
        end
        FULL: begin
          if (accept && pop) begin
            head_load = 1'b1;
          end else if (accept && (SKID != 0)) begin
            next_state = SKIDFULL;
            skid_load  = 1'b1;
          end else if (pop) begin
            next_state = EMPTY;
          end
        end
        SKIDFULL: begin
          if (pop) begin
            next_state     = FULL;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  assign head_d = head_from_skid ? skid_q : in_data;

  // State, registered in_ready and the stall counter. Flush suppresses the
  // stall increment; clr_cnt overrides any increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != SKIDFULL);
      if (clr_cnt) begin
        stall_q <= '0;
      end else if (out_valid && !out_ready && !flush && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  pipe_stage_reg_dreg #(
    .WIDTH   (WIDTH),
    .RST_VAL (BUBBLE)
  ) u_head (
    .clk (clk),
    .rst (rst),
    .en  (head_load),
    .d   (head_d),
    .q   (head_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_stage_reg_dreg #(
        .WIDTH   (WIDTH),
        .RST_VAL (BUBBLE)
      ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_load),
        .d   (in_data),
        .q   (skid_q)
      );
    end else begin : g_noskid
      assign skid_q = BUBBLE;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a skid instance checked by a
// queue-based scoreboard under directed and random traffic, plus a
// single-entry instance checked directly.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic        clr_cnt;
  logic [3:0]  stall_cnt;
  logic [1:0]  occupancy;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_data;
  logic        b_flush;
  logic        b_clr_cnt;
  logic [7:0]  b_stall_cnt;
  logic [1:0]  b_occupancy;

  int          tests;
  int          failures;

  logic [31:0] exp_q[$];
  int          stall_m;
  logic        exp_in_ready;
  logic        had_head;

  pipe_stage_reg #(
    .WIDTH  (32),
    .SKID   (1),
    .BUBBLE (PIPE_NOP),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt),
    .occupancy (occupancy)
  );

  pipe_stage_reg #(
    .WIDTH  (8),
    .SKID   (0),
    .BUBBLE (8'h00),
    .CNT_W  (8)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .flush     (b_flush),
    .clr_cnt   (b_clr_cnt),
    .stall_cnt (b_stall_cnt),
    .occupancy (b_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
  endtask

  task automatic resetModel();
    exp_q.delete();
    stall_m      = 0;
    exp_in_ready = 1'b1;
    had_head     = 1'b0;
  endtask

  // Reference model: the queue holds the beats the stage owes downstream, in
  // order. A beat is accepted when offered while fewer than two are held.
  always @(posedge clk) begin
    if (rst) begin
      if (clr_cnt) stall_m = 0;
      else if (had_head && !out_ready && !flush && stall_m < 15) stall_m = stall_m + 1;
      if (flush) exp_q.delete();
      else if (in_valid && exp_in_ready) exp_q.push_back(in_data);
    end
  end

  // Monitor: compares presented outputs against the scoreboard mid-cycle and
  // retires the head when downstream takes it.
  always @(negedge clk) begin : monitor
    int sz;
    if (rst) begin
      sz = exp_q.size();
      checkOutput("out_valid", {63'd0, out_valid}, {63'd0, sz > 0});
      if (sz > 0) checkOutput("out_data", {32'd0, out_data}, {32'd0, exp_q[0]});
      else        checkOutput("bubble", {32'd0, out_data}, {32'd0, PIPE_NOP});
      checkOutput("occupancy", {62'd0, occupancy}, 64'(sz));
      checkOutput("in_ready", {63'd0, in_ready}, {63'd0, sz != 2});
      checkOutput("stall_cnt", {60'd0, stall_cnt}, 64'(stall_m));
      exp_in_ready = (sz != 2);
      had_head     = (sz > 0);
      if (sz > 0 && out_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    tests    = 0;
    failures = 0;
    rst      = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    b_in_valid  = 1'b0;
    b_in_data   = 8'd0;
    b_out_ready = 1'b0;
    b_flush     = 1'b0;
    b_clr_cnt   = 1'b0;
    resetModel();

    // Values held during reset
    step();
    step();
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_data", {32'd0, out_data}, {32'd0, PIPE_NOP});
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_stall", {60'd0, stall_cnt}, 64'd0);
    checkOutput("rst_occ", {62'd0, occupancy}, 64'd0);
    checkOutput("rst_b_in_ready", {63'd0, b_in_ready}, 64'd1);
    rst = 1'b1;

    // Single-entry stage: in_ready follows out_ready within the cycle
    b_in_valid  = 1'b1;
    b_in_data   = 8'hA5;
    b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    checkOutput("b_valid", {63'd0, b_out_valid}, 64'd1);
    checkOutput("b_data", {56'd0, b_out_data}, 64'hA5);
    b_out_ready = 1'b1; #1;
    checkOutput("b_rdy_1", {63'd0, b_in_ready}, 64'd1);
    b_out_ready = 1'b0; #1;
    checkOutput("b_rdy_0", {63'd0, b_in_ready}, 64'd0);
    b_out_ready = 1'b1; #1;
    checkOutput("b_rdy_1b", {63'd0, b_in_ready}, 64'd1);
    b_in_valid = 1'b1;
    b_in_data  = 8'h3C;
    step();
    b_in_valid = 1'b0;
    checkOutput("b_replace_valid", {63'd0, b_out_valid}, 64'd1);
    checkOutput("b_replace_data", {56'd0, b_out_data}, 64'h3C);
    checkOutput("b_replace_occ", {62'd0, b_occupancy}, 64'd1);
    step();
    checkOutput("b_empty_valid", {63'd0, b_out_valid}, 64'd0);
    checkOutput("b_empty_data", {56'd0, b_out_data}, 64'h00);
    b_out_ready = 1'b0;

    // Back-to-back stream
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    step();

    // Back-pressure: two beats held for five stalled cycles
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1); step();
    applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0); step();
    end
    checkOutput("bp_stall", {60'd0, stall_cnt}, 64'd5);
    checkOutput("bp_occ", {62'd0, occupancy}, 64'd2);
    checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("bp_head", {32'd0, out_data}, 64'hAAAA_0001);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    step();

    // Saturation and clear-over-increment
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0); step();
    end
    checkOutput("sat_stall", {60'd0, stall_cnt}, 64'd15);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1); step();
    checkOutput("clr_stall", {60'd0, stall_cnt}, 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0); step(); step();

    // Flush while FULL with an incoming beat
    applyStimulus(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 32'hCCCC_CCCC, 1'b0, 1'b1, 1'b0); step();
    checkOutput("flush_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("flush_bubble", {32'd0, out_data}, {32'd0, PIPE_NOP});
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0); step(); step();

    // Asynchronous reset while SKIDFULL
    applyStimulus(1'b1, 32'h0000_00A1, 1'b0, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 32'h0000_00B2, 1'b0, 1'b0, 1'b0); step();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_occ", {62'd0, occupancy}, 64'd2);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("arst_occ", {62'd0, occupancy}, 64'd0);
    checkOutput("arst_data", {32'd0, out_data}, {32'd0, PIPE_NOP});
    resetModel();
    step();
    rst = 1'b1;

    // First accept right after reset release, then random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      step();
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    step();
    checkOutput("drain_empty", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
